// File: rtl/elevator_fsm_top.sv
// Single-car SCAN elevator: request latch, floor tracking, motion/door FSM
// with safety overrides, and a free-running PWM motor drive.

module elevator_ctrl #(
    parameter int NUM_FLOORS       = 10,
    parameter int FLOOR_WIDTH      = 4,
    parameter int DOOR_OPEN_CYCLES = 20,
    parameter int PWM_MOVE_DUTY    = 192
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   emergency_stop,
    input  logic                   overweight,
    input  logic                   door_obstruction,
    input  logic [NUM_FLOORS-1:0]  floor_requests,
    input  logic [FLOOR_WIDTH-1:0] current_floor,
    output logic                   clear_current_request,
    output logic [7:0]             pwm_duty,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open
);
    localparam int CW = (DOOR_OPEN_CYCLES > 1) ? $clog2(DOOR_OPEN_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DOOR_OPEN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN,
        EMERGENCY
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] dwell_q;
    logic          last_up_q;
    logic          above, below, here, hold;

    assign hold = overweight | door_obstruction;

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(current_floor)) above = above | floor_requests[i];
            if (i < int'(current_floor)) below = below | floor_requests[i];
            if (i == int'(current_floor)) here = floor_requests[i];
        end
    end

    always_comb begin
        state_d = state_q;
        clear_current_request = 1'b0;
        if (emergency_stop) begin
            state_d = EMERGENCY;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // a stop-side hold opens the door even with no call here
                    if (here || hold) begin
                        state_d = DOOR_OPEN;
                        clear_current_request = here;
                    end else if (last_up_q && above) begin
                        state_d = MOVE_UP;
                    end else if (below) begin
                        state_d = MOVE_DOWN;
                    end else if (above) begin
                        state_d = MOVE_UP;
                    end
                end
                MOVE_UP: begin
                    if (here) begin
                        state_d = DOOR_OPEN;
                        clear_current_request = 1'b1;
                    end else if (!above) begin
                        state_d = IDLE;
                    end
                end
                MOVE_DOWN: begin
                    if (here) begin
                        state_d = DOOR_OPEN;
                        clear_current_request = 1'b1;
                    end else if (!below) begin
                        state_d = IDLE;
                    end
                end
                DOOR_OPEN: begin
                    if (!hold && dwell_q == '0) state_d = IDLE;
                end
                EMERGENCY: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dwell_q     <= '0;
            last_up_q   <= 1'b1;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
            door_open   <= 1'b0;
            pwm_duty    <= 8'd0;
        end else begin
            state_q     <= state_d;
            moving_up   <= (state_d == MOVE_UP);
            moving_down <= (state_d == MOVE_DOWN);
            door_open   <= (state_d == DOOR_OPEN);
            pwm_duty    <= (state_d == MOVE_UP || state_d == MOVE_DOWN)
                           ? 8'(PWM_MOVE_DUTY) : 8'd0;
            if (state_d == DOOR_OPEN) begin
                if (state_q != DOOR_OPEN || hold) begin
                    dwell_q <= DWELL_LOAD;
                end else if (dwell_q != '0) begin
                    dwell_q <= dwell_q - CW'(1);
                end
            end
            if (state_d == MOVE_UP && state_q != MOVE_UP) begin
                last_up_q <= 1'b1;
            end else if (state_d == MOVE_DOWN && state_q != MOVE_DOWN) begin
                last_up_q <= 1'b0;
            end
        end
    end
endmodule

module elevator_fsm_top #(
    parameter int NUM_FLOORS       = 10,
    parameter int FLOOR_WIDTH      = 4,
    parameter int DOOR_OPEN_CYCLES = 20,
    parameter int PWM_MOVE_DUTY    = 192
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   emergency_stop,
    input  logic                   overweight,
    input  logic                   door_obstruction,
    input  logic [NUM_FLOORS-1:0]  new_requests,
    input  logic [NUM_FLOORS-1:0]  floor_sensors,
    output logic [NUM_FLOORS-1:0]  floor_requests,
    output logic [FLOOR_WIDTH-1:0] current_floor,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open,
    output logic                   pwm_out
);
    logic [NUM_FLOORS-1:0]  req_q, req_d, clear_mask;
    logic [FLOOR_WIDTH-1:0] floor_q, floor_d;
    logic [7:0]             pwm_cnt_q;
    logic [7:0]             pwm_duty;
    logic                   clear_current_request;

    always_comb begin
        floor_d = floor_q;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (floor_sensors[i]) floor_d = FLOOR_WIDTH'(i);
        end
    end

    // while the door is open, calls for this floor are swallowed
    assign clear_mask = (clear_current_request | door_open)
                        ? (NUM_FLOORS'(1) << floor_q) : '0;
    assign req_d = (req_q | new_requests) & ~clear_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= '0;
            floor_q   <= '0;
            pwm_cnt_q <= 8'd0;
        end else begin
            req_q     <= req_d;
            floor_q   <= floor_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end

    assign pwm_out        = (pwm_cnt_q < pwm_duty);
    assign floor_requests = req_q;
    assign current_floor  = floor_q;

    elevator_ctrl #(
        .NUM_FLOORS      (NUM_FLOORS),
        .FLOOR_WIDTH     (FLOOR_WIDTH),
        .DOOR_OPEN_CYCLES(DOOR_OPEN_CYCLES),
        .PWM_MOVE_DUTY   (PWM_MOVE_DUTY)
    ) controller (
        .clk                  (clk),
        .reset                (reset),
        .emergency_stop       (emergency_stop),
        .overweight           (overweight),
        .door_obstruction     (door_obstruction),
        .floor_requests       (req_q),
        .current_floor        (floor_q),
        .clear_current_request(clear_current_request),
        .pwm_duty             (pwm_duty),
        .moving_up            (moving_up),
        .moving_down          (moving_down),
        .door_open            (door_open)
    );
endmodule

// File: tb/tb_elevator_fsm_top.sv
// Bench for elevator_fsm_top: vector table for the upward trip, then
// hand sequences for holds, emergency stop, downward trip and reset.

module tb_elevator_fsm_top;
    localparam int NF = 10;
    localparam int FW = 4;
    localparam int OW = NF + FW + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          emergency_stop, overweight, door_obstruction;
    logic [NF-1:0] new_requests, floor_sensors, floor_requests;
    logic [FW-1:0] current_floor;
    logic          moving_up, moving_down, door_open, pwm_out;

    always #5 clk = ~clk;

    elevator_fsm_top #(
        .NUM_FLOORS      (NF),
        .FLOOR_WIDTH     (FW),
        .DOOR_OPEN_CYCLES(20),
        .PWM_MOVE_DUTY   (192)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .emergency_stop  (emergency_stop),
        .overweight      (overweight),
        .door_obstruction(door_obstruction),
        .new_requests    (new_requests),
        .floor_sensors   (floor_sensors),
        .floor_requests  (floor_requests),
        .current_floor   (current_floor),
        .moving_up       (moving_up),
        .moving_down     (moving_down),
        .door_open       (door_open),
        .pwm_out         (pwm_out)
    );

    typedef struct {
        string         name;
        logic [NF-1:0] nreq;
        logic [NF-1:0] sens;
        int            cyc;
        logic [OW-1:0] exp;
    } vec_t;

    typedef struct {
        string         name;
        logic [OW-1:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(string n, logic [NF-1:0] nr,
                                logic [NF-1:0] s, int c,
                                logic [NF-1:0] r, logic [FW-1:0] f,
                                logic [2:0] udd);
        vec_t v;
        v.name = n;
        v.nreq = nr;
        v.sens = s;
        v.cyc  = c;
        v.exp  = {r, f, udd};
        return v;
    endfunction

    task automatic count_door(output int n);
        n = 0;
        while (door_open && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic count_pwm(input int cycles, output int h);
        h = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pwm_out) h++;
            step();
        end
    endtask

    initial begin
        int   n, h, mv;
        sb_t  e;
        logic [OW-1:0] got;

        reset = 1'b1;
        emergency_stop = 1'b0;
        overweight = 1'b0;
        door_obstruction = 1'b0;
        new_requests = '0;
        floor_sensors = 10'h001;

        // --- reset state ---
        count_pwm(5, h);
        check("rst_pwm", 32'(h), 32'd0);
        check("rst_req", 32'(floor_requests), 32'd0);
        check("rst_floor", 32'(current_floor), 32'd0);
        check("rst_outs", 32'({moving_up, moving_down, door_open}), 32'd0);
        check("rst_duty", 32'(dut.controller.pwm_duty), 32'd0);
        reset = 1'b0;

        // --- upward trip 0 -> 3 -> 5 -> 9; exp = {req, floor, up, dn, door} ---
        tbl.push_back(mk("idle0",   10'h000, 10'h001,  1, 10'h000, 4'd0, 3'b000));
        tbl.push_back(mk("latch",   10'h228, 10'h001,  1, 10'h228, 4'd0, 3'b000));
        tbl.push_back(mk("start",   10'h000, 10'h001,  1, 10'h228, 4'd0, 3'b100));
        tbl.push_back(mk("flr1",    10'h000, 10'h002,  1, 10'h228, 4'd1, 3'b100));
        tbl.push_back(mk("between", 10'h000, 10'h000,  1, 10'h228, 4'd1, 3'b100));
        tbl.push_back(mk("flr2",    10'h000, 10'h004,  1, 10'h228, 4'd2, 3'b100));
        tbl.push_back(mk("flr3",    10'h000, 10'h008,  1, 10'h228, 4'd3, 3'b100));
        tbl.push_back(mk("stop3",   10'h000, 10'h008,  1, 10'h220, 4'd3, 3'b001));
        tbl.push_back(mk("dwell3",  10'h000, 10'h008, 19, 10'h220, 4'd3, 3'b001));
        tbl.push_back(mk("close3",  10'h000, 10'h008,  1, 10'h220, 4'd3, 3'b000));
        tbl.push_back(mk("resume3", 10'h000, 10'h008,  1, 10'h220, 4'd3, 3'b100));
        tbl.push_back(mk("flr4",    10'h000, 10'h010,  1, 10'h220, 4'd4, 3'b100));
        tbl.push_back(mk("stop5",   10'h000, 10'h020,  2, 10'h200, 4'd5, 3'b001));
        tbl.push_back(mk("dwell5",  10'h000, 10'h020, 19, 10'h200, 4'd5, 3'b001));
        tbl.push_back(mk("close5",  10'h000, 10'h020,  1, 10'h200, 4'd5, 3'b000));
        tbl.push_back(mk("resume5", 10'h000, 10'h020,  1, 10'h200, 4'd5, 3'b100));
        tbl.push_back(mk("flr6",    10'h000, 10'h040,  1, 10'h200, 4'd6, 3'b100));
        tbl.push_back(mk("flr7",    10'h000, 10'h080,  1, 10'h200, 4'd7, 3'b100));
        tbl.push_back(mk("flr8",    10'h000, 10'h100,  1, 10'h200, 4'd8, 3'b100));
        tbl.push_back(mk("stop9",   10'h000, 10'h200,  2, 10'h000, 4'd9, 3'b001));
        tbl.push_back(mk("dwell9",  10'h000, 10'h200, 19, 10'h000, 4'd9, 3'b001));
        tbl.push_back(mk("close9",  10'h000, 10'h200,  1, 10'h000, 4'd9, 3'b000));
        tbl.push_back(mk("idle9",   10'h000, 10'h200,  5, 10'h000, 4'd9, 3'b000));

        foreach (tbl[i]) begin
            new_requests  = tbl[i].nreq;
            floor_sensors = tbl[i].sens;
            sbq.push_back('{tbl[i].name, tbl[i].exp});
            for (int c = 0; c < tbl[i].cyc; c++) begin
                step();
                new_requests = '0;
            end
            got = {floor_requests, current_floor,
                   moving_up, moving_down, door_open};
            e = sbq.pop_front();
            n_chk++;
            if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got {req,flr,up,dn,door}=%h expected %h",
                         e.name, got, e.exp);
            end
        end

        // --- obstruction held 60 cycles at floor 9 ---
        door_obstruction = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (door_open) n++;
        end
        check("obs_hold", 32'(n), 32'd60);
        door_obstruction = 1'b0;
        count_door(n);
        check("obs_dwell", 32'(n), 32'd20);
        check("obs_idle", 32'({moving_up, moving_down, door_open}), 32'd0);
        count_pwm(256, h);
        check("pwm_idle", 32'(h), 32'd0);

        // --- overweight with calls 1 and 4 posted during the hold ---
        overweight = 1'b1;
        n = 0;
        mv = 0;
        for (int i = 0; i < 60; i++) begin
            new_requests = (i == 1) ? 10'h012 : 10'h000;
            step();
            if (door_open) n++;
            if (moving_up || moving_down) mv++;
        end
        new_requests = '0;
        check("ow_hold", 32'(n), 32'd60);
        check("ow_no_move", 32'(mv), 32'd0);
        check("ow_req", 32'(floor_requests), 32'h012);
        overweight = 1'b0;
        count_door(n);
        check("ow_dwell", 32'(n), 32'd20);
        check("ow_gap", 32'({moving_up, moving_down}), 32'd0);
        step();
        check("down_start", 32'({moving_up, moving_down}), 32'b01);

        // --- PWM while moving ---
        check("duty_move", 32'(dut.controller.pwm_duty), 32'd192);
        count_pwm(256, h);
        check("pwm_75", 32'(h), 32'd192);

        // --- emergency stop during MOVE_DOWN ---
        emergency_stop = 1'b1;
        step();
        check("estop_out",
              32'({moving_up, moving_down, door_open, pwm_out}), 32'd0);
        check("estop_req", 32'(floor_requests), 32'h012);
        h = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (pwm_out || moving_up || moving_down || door_open) h++;
        end
        check("estop_quiet", 32'(h), 32'd0);
        emergency_stop = 1'b0;
        n = 0;
        while (!moving_down && n < 10) begin
            step();
            n++;
        end
        check("estop_resume", 32'(moving_down), 32'd1);

        // --- descend 9 -> 4 -> 1 ---
        for (int f = 8; f >= 5; f--) begin
            floor_sensors = NF'(1) << f;
            step();
        end
        check("flr5_down", 32'(current_floor), 32'd5);
        check("clr_idle", 32'(dut.controller.clear_current_request), 32'd0);
        floor_sensors = 10'h010;
        step();
        check("clr_pulse", 32'(dut.controller.clear_current_request), 32'd1);
        step();
        check("stop4", 32'({floor_requests, door_open}), 32'({10'h002, 1'b1}));
        new_requests = 10'h010;
        step();
        new_requests = '0;
        check("discard4", 32'(floor_requests), 32'h002);
        count_door(n);
        check("dwell4", 32'(n), 32'd19);
        n = 0;
        while (!moving_down && n < 10) begin
            step();
            n++;
        end
        check("resume_down", 32'(moving_down), 32'd1);
        for (int f = 3; f >= 1; f--) begin
            floor_sensors = NF'(1) << f;
            step();
        end
        step();
        check("stop1", 32'({floor_requests, door_open}), 32'({10'h000, 1'b1}));
        count_door(n);
        check("dwell1", 32'(n), 32'd20);
        repeat (3) step();
        check("idle1", 32'({floor_requests, current_floor,
                            moving_up, moving_down, door_open}),
              32'({10'h000, 4'd1, 3'b000}));

        // --- reset while moving ---
        new_requests = 10'h080;
        step();
        new_requests = '0;
        step();
        check("up_to7", 32'(moving_up), 32'd1);
        floor_sensors = 10'h004;
        step();
        reset = 1'b1;
        new_requests = 10'h3FF;
        door_obstruction = 1'b1;
        emergency_stop = 1'b1;
        step();
        step();
        check("mrst_req", 32'(floor_requests), 32'd0);
        check("mrst_floor", 32'(current_floor), 32'd0);
        check("mrst_outs",
              32'({moving_up, moving_down, door_open, pwm_out}), 32'd0);
        reset = 1'b0;
        new_requests = '0;
        door_obstruction = 1'b0;
        emergency_stop = 1'b0;
        floor_sensors = '0;
        step();
        check("post_rst", 32'({floor_requests, current_floor,
                               moving_up, moving_down, door_open}), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/elevator_fsm_top.md
# elevator_fsm_top

Single-car elevator controller for a building of NUM_FLOORS floors. It latches hall/car call requests and tracks the car position from one-hot floor sensors. A directional (SCAN) state machine drives up/down motion and door control. The motor command is a PWM output. Safety inputs (emergency stop, overweight, door obstruction) override normal service. It sits between the button/sensor front end and the motor and door drivers.

## Interface
- NUM_FLOORS, default 10: number of floors, 2..16.
- FLOOR_WIDTH, default 4: width of the floor index; must satisfy 2^FLOOR_WIDTH ≥ NUM_FLOORS.
- DOOR_OPEN_CYCLES, default 20: door dwell time in clock cycles.
- PWM_MOVE_DUTY, default 192: 8-bit motor duty while moving.
- clk, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: synchronous, active-high.
- emergency_stop, input, 1: highest-priority halt.
- overweight, input, 1: blocks departure; holds the door open.
- door_obstruction, input, 1: holds or reopens the door.
- new_requests, input, NUM_FLOORS: call pulses or levels, bit i = floor i.
- floor_sensors, input, NUM_FLOORS: one-hot car position; all-zero means between floors.
- floor_requests, output, NUM_FLOORS: pending request register.
- current_floor, output, FLOOR_WIDTH: last sensed floor index.
- moving_up, output, 1: motor up command.
- moving_down, output, 1: motor down command. Never asserted together with moving_up.
- door_open, output, 1: door open command.
- pwm_out, output, 1: motor PWM.
- Hierarchy: the FSM lives in an instance named controller. That instance exposes clear_current_request (1 bit) and pwm_duty (8 bits) for bench probing.

## Operation
- The controller FSM has five states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, EMERGENCY. Reset state is IDLE.
- Request register update each cycle: floor_requests ← (floor_requests | new_requests) & ~clear_mask.
  - clear_mask is one-hot at current_floor when clear_current_request = 1, otherwise 0.
  - While in DOOR_OPEN, new_requests bits for current_floor are discarded (clear wins).
- Position tracking: current_floor ← index of the lowest set bit of floor_sensors. If floor_sensors == 0, current_floor holds its value.
- last_dir register, reset to up. It is updated on every entry to MOVE_UP or MOVE_DOWN.
- Derived terms from floor_requests and current_floor:
  - above = any request bit with index > current_floor.
  - below = any request bit with index < current_floor.
  - here = floor_requests[current_floor].
- Transition priority (highest first):
  1. emergency_stop = 1, from any state → EMERGENCY.
  2. IDLE:
     - here, overweight or door_obstruction → DOOR_OPEN.
     - else last_dir = up and above → MOVE_UP.
     - else below → MOVE_DOWN.
     - else above → MOVE_UP.
     - else stay in IDLE.
  3. MOVE_UP:
     - here → DOOR_OPEN.
     - else no above → IDLE.
  4. MOVE_DOWN:
     - here → DOOR_OPEN.
     - else no below → IDLE.
  5. DOOR_OPEN: the dwell counter loads DOOR_OPEN_CYCLES−1 on entry and decrements each cycle.
     - While overweight or door_obstruction is asserted, the counter reloads.
     - At 0 → IDLE.
  6. EMERGENCY: when emergency_stop = 0 → IDLE. Pending requests are retained throughout.
- overweight and door_obstruction are ignored in MOVE states. They act only at stops.
- clear_current_request = 1 on the cycle the FSM enters DOOR_OPEN with here = 1. This includes IDLE → DOOR_OPEN entries.
- Outputs (registered from state):
  - moving_up = (state == MOVE_UP).
  - moving_down = (state == MOVE_DOWN).
  - door_open = (state == DOOR_OPEN).
  - pwm_duty = PWM_MOVE_DUTY in MOVE states, otherwise 0.
- PWM: an 8-bit free-running counter, reset to 0, wraps 255→0 (256-cycle period). pwm_out = (counter < pwm_duty). Duty 0 gives a constant 0.

## Timing
- Reset values: floor_requests = 0, current_floor = 0, all motion, door and pwm outputs = 0, PWM counter = 0, state IDLE.
- A new_requests bit appears in floor_requests 1 cycle later.
- A floor_sensors change appears in current_floor 1 cycle later. The FSM reacts to it 1 cycle after that.
- Stop latency: request bit present at the sensed floor → door_open = 1 and the bit cleared within 2 cycles of current_floor updating.
- Door dwell is exactly DOOR_OPEN_CYCLES cycles after the last cycle with obstruction/overweight asserted.
- emergency_stop drops motion/door/pwm outputs 1 cycle after assertion.
- Reset mid-operation clears requests and position, regardless of other inputs.

## Test plan
- Reset 5 cycles, sensor at floor 0, no requests → current_floor = 0, all outputs 0, pwm_out constantly 0.
- Requests 3, 5, 9 with the car at 0 → floor_requests = 0b1000101000, moving_up = 1, pwm_out duty 75%. As sensors step 1..9, the car stops at 3, then 5, then 9: door_open = 1 for 20 cycles at each stop, the matching bit is cleared, and motion resumes up. At 9, idle with floor_requests = 0.
- Door obstruction at floor 9 idle for 60 cycles → door_open = 1 throughout and for 20 cycles after release, then 0.
- Overweight for 60 cycles at idle → same as obstruction. With a pending request above or below, no motion until overweight has been released and the dwell has expired.
- Emergency stop during MOVE_DOWN → next cycle all motion/door/pwm outputs are 0. Requests are retained, and service resumes after release.
- Car at 9, requests 1 and 4 → moving_down; stops at 4 then 1 with doors open and bits cleared. A simultaneous request at the current floor while the door is open is discarded.
